decode_rr_arbiter: RTL
======================

DECODE_RR_ARBITER -- requirements
Module: decode_rr_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 16, maximum consecutive cycles one requester may hold a grant (legal 2..256).
REQ-002 Parameter: NREQ, fixed 8, number of requesters, one per decoder output line.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  arbiter enable, active-high, analogous to decoder G enable.
REQ-006 req  input  8  request vector, active-high, bit i = requester i.
REQ-007 Y_n  output  8  registered active-low one-hot select; 8'hFF = nobody selected.
REQ-008 gnt_idx  output  3  registered index of current owner, C/B/A order (bit 2 = C).
REQ-009 gnt_valid  output  1  registered, high while a grant is held.
REQ-010 expired  output  1  registered one-cycle pulse, high on the cycle a grant is forcibly revoked by timeout.

Function
REQ-011 The block SHALL implement states IDLE, GRANT and GAP.
REQ-012 Arbitration SHALL search req from index ptr upward, wrapping 7->0, and pick the first set bit.
REQ-013 In IDLE or GAP with en=1 and req!=0, the next edge SHALL enter GRANT with the winner; grant is visible one cycle after the request is sampled.
REQ-014 In IDLE with en=0 or req=0, the block SHALL stay in IDLE; in GAP under the same condition, it SHALL go to IDLE.
REQ-015 In GRANT, Y_n SHALL equal ~(8'b1 << gnt_idx), gnt_valid=1, and exactly one Y_n bit SHALL be low.
REQ-016 In IDLE and GAP, Y_n SHALL be 8'hFF and gnt_valid=0; gnt_idx SHALL keep its last value.
REQ-017 GRANT SHALL persist while en=1, req[gnt_idx]=1 and hold_cnt < HOLD_MAX-1.
REQ-018 hold_cnt SHALL be 0 on the first GRANT cycle and increment each GRANT cycle; width SHALL be $clog2(HOLD_MAX).
REQ-019 Release on req[gnt_idx]=0 or en=0 SHALL enter GAP on the next edge; expired SHALL stay 0.
REQ-020 Release at hold_cnt==HOLD_MAX-1 with req[gnt_idx]=1 and en=1 SHALL enter GAP and assert expired for exactly that GAP cycle.
REQ-021 Any release SHALL set ptr = gnt_idx+1 mod 8, so the released requester has lowest priority.
REQ-022 GAP SHALL last exactly one cycle, giving break-before-make: two grants never overlap or abut.
REQ-023 A new request arriving in the same cycle as a release SHALL be evaluated only in GAP; it is never merged into the current grant.
REQ-024 If requesters drop and reassert during GAP, the request value sampled at the GAP edge SHALL decide the next grant.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force the following values: state=IDLE, Y_n=8'hFF, gnt_idx=0, gnt_valid=0, expired=0, ptr=0 and hold_cnt=0. This applies even mid-grant.
REQ-026 After rst_n deasserts, the first arbitration SHALL start from ptr=0.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, GRANT, GAP) and the constants NREQ=8 and IDX_W=3.
REQ-028 The Y_n generation SHALL be one sub-module, onehot_dec_n: 3-to-8 active-low decoder with active-high enable, fed gnt_idx and the GRANT-state flag.
REQ-029 All outputs SHALL come from registers; there is no combinational path from req or en to any output.

Verification
REQ-030 Reset behaviour: reset, then req=8'h00 and en=1 for 5 cycles -> Y_n=8'hFF, gnt_valid=0 and expired=0 throughout.
REQ-031 Basic grant and release: req=8'h04 -> one cycle later Y_n=8'hFB and gnt_idx=2; drop req -> one GAP cycle with Y_n=8'hFF, then IDLE.
REQ-032 Round robin: req=8'h81 held, HOLD_MAX=4 -> grants alternate 0,7,0,7, each 4 cycles with one GAP between; expired pulses on each GAP.
REQ-033 Enable: en=0 with req=8'hFF -> no grant ever; en dropped mid-grant at idx 3 -> GAP next edge, expired=0, ptr=4.
REQ-034 Wrap-around: ptr=6 after releasing 5, req=8'h03 -> grant idx 0, then idx 1 after release.
REQ-035 Reset mid-grant: rst_n pulled low during a grant of idx 5 -> Y_n=8'hFF with no clock edge; after release, req=8'h60 -> grant idx 5 (ptr=0 search).

Source files
------------

// File: rtl/decode_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter with active-low
// decoded select.
package decode_rr_arbiter_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // First set request at or above ptr, wrapping 7->0; ptr itself when none set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decode_rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
interface decode_rr_arbiter_if
  import decode_rr_arbiter_pkg::*;
  ();

  logic             en;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  Y_n;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             expired;

  modport master (
    output en, req,
    input  Y_n, gnt_idx, gnt_valid, expired
  );

  modport slave (
    input  en, req,
    output Y_n, gnt_idx, gnt_valid, expired
  );

endinterface

// File: rtl/decode_rr_arbiter_onehot_dec_n.sv
// 3-to-8 active-low decoder with active-high enable.
module onehot_dec_n
  import decode_rr_arbiter_pkg::*;
  (
    input  logic             g,
    input  logic [IDX_W-1:0] sel,
    output logic [NREQ-1:0]  y_n
  );

  always_comb begin
    y_n = '1;
    if (g) begin
      y_n[sel] = 1'b0;
    end
  end

endmodule

// File: rtl/decode_rr_arbiter.sv
// Round-robin arbiter over 8 requesters with hold timeout and a one-cycle
// break-before-make gap between grants; all outputs are registered.
module decode_rr_arbiter
  import decode_rr_arbiter_pkg::*;
  #(
    parameter int HOLD_MAX = 16
  )
  (
    input  logic         clk,
    input  logic         rst_n,
    decode_rr_arbiter_if.slave bus
  );

  localparam int               CNT_W     = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             expired_q, expired_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [NREQ-1:0]  y_n_q, y_n_d;

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    expired_d  = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (bus.en && (|bus.req)) begin
          state_d    = GRANT;
          gnt_idx_d  = rr_pick(bus.req, ptr_q);
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // A request raised during the release cycle waits for the GAP decision.
        if (!bus.en || !bus.req[gnt_idx_q]) begin
          state_d = GAP;
          ptr_d   = gnt_idx_q + 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = GAP;
          ptr_d     = gnt_idx_q + 1'b1;
          expired_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_valid_d = (state_d == GRANT);
  end

  // Decode the next owner so Y_n can be captured in a flop alongside gnt_idx.
  onehot_dec_n u_dec (
    .g   (gnt_valid_d),
    .sel (gnt_idx_d),
    .y_n (y_n_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      expired_q   <= 1'b0;
      gnt_valid_q <= 1'b0;
      y_n_q       <= '1;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      expired_q   <= expired_d;
      gnt_valid_q <= gnt_valid_d;
      y_n_q       <= y_n_d;
    end
  end

  assign bus.Y_n       = y_n_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.expired   = expired_q;

endmodule
